// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the RV32M multiply/divide unit:
//                funct3 operation codes, FSM state encoding and the fixed
//                operation latency in clock edges.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // funct3 operation codes of the M extension
    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } mdu_state_t;

    // Edges from the accepting edge to the edge that raises done (WIDTH + 2)
    localparam int MDU_LATENCY = 34;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_iter_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iter_datapath
//  Description : One-bit-per-step iterative register pair shared by multiply
//                and divide. Operands must already be unsigned magnitudes.
//                  multiply : {o_hi,o_lo} = i_op_a * i_op_b after WIDTH steps
//                  divide   : o_lo = i_op_a / i_op_b, o_hi = i_op_a % i_op_b
//  Ports       : clk, reset (async, active-low)
//                i_load  - load operands and clear the accumulator
//                i_step  - perform one iteration
//                i_div   - 1 = restoring divide, 0 = shift-add multiply
//                i_op_a  - multiplicand / dividend magnitude
//                i_op_b  - multiplier / divisor magnitude
//                o_hi    - product high word / remainder
//                o_lo    - product low word / quotient
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opd;   // multiplicand or divisor, held for all steps

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_trial;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    always_comb begin
        // Multiply: conditionally add, then shift the whole pair right with
        // the carry entering the top of r_hi.
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
        // Divide: shift the next dividend bit into the partial remainder and
        // try subtracting the divisor.  The partial remainder is always less
        // than the divisor, so bit WIDTH of the trial is a clean borrow flag.
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_trial = w_div_shift - {1'b0, r_opd};

        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (i_div) begin
            if (w_div_trial[WIDTH]) begin
                w_hi_nxt = w_div_shift[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end else begin
                w_hi_nxt = w_div_trial[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            w_hi_nxt = w_mul_sum[WIDTH:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_opd <= '0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_div ? i_op_a : i_op_b;
            r_opd <= i_div ? i_op_b : i_op_a;
        end else if (i_step) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule : mdu_iter_datapath
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative RV32M multiply/divide unit. Accepts an M-extension
//                op in IDLE, runs PREP -> CALC (WIDTH steps) -> FIX -> DONE
//                and presents a one-cycle done pulse with the writeback value.
//                Optional macro MDU_EARLY_OUT_EN: divide-by-zero, signed
//                overflow and zero multiply operands skip CALC.
//  Ports       : clk, reset (async, active-low)
//                start, funct3, rs1_data, rs2_data, rd_in, flush  - request
//                busy, done, result, rd_out, write_enable         - response
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out,
    output logic             write_enable
);

    localparam int               CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_int_min  = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_t       r_state;
    logic [2:0]       r_f3;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [4:0]       r_rd;
    logic             r_neg;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_we;
    logic [WIDTH-1:0] r_result;

    logic             w_is_div;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_sa;
    logic             w_sb;
    logic             w_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_dp_hi;
    logic [WIDTH-1:0] w_dp_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_fix_result;
    mdu_state_t       w_prep_next;

    // ------------------------------------------------------------------------
    // Operand signedness and magnitudes (from the latched operands)
    // ------------------------------------------------------------------------
    assign w_is_div = r_f3[2];

    always_comb begin
        w_a_signed = (r_f3 == MDU_MUL) || (r_f3 == MDU_MULH) ||
                     (r_f3 == MDU_MULHSU) || (r_f3 == MDU_DIV) ||
                     (r_f3 == MDU_REM);
        w_b_signed = (r_f3 == MDU_MUL) || (r_f3 == MDU_MULH) ||
                     (r_f3 == MDU_DIV) || (r_f3 == MDU_REM);
        w_sa       = w_a_signed & r_a[WIDTH-1];
        w_sb       = w_b_signed & r_b[WIDTH-1];
        // Remainder takes the dividend's sign; everything else is sA^sB.
        w_neg      = (r_f3 == MDU_REM) ? w_sa : (w_sa ^ w_sb);
        w_abs_a    = w_sa ? (~r_a + 1'b1) : r_a;
        w_abs_b    = w_sb ? (~r_b + 1'b1) : r_b;
        w_div0     = (r_b == '0);
        w_ovf      = ((r_f3 == MDU_DIV) || (r_f3 == MDU_REM)) &&
                     (r_a == c_int_min) && (r_b == '1);
    end

    // ------------------------------------------------------------------------
    // Iterative datapath: loaded in PREP, stepped every CALC cycle
    // ------------------------------------------------------------------------
    mdu_iter_datapath #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .i_load (r_state == S_PREP),
        .i_step (r_state == S_CALC),
        .i_div  (w_is_div),
        .i_op_a (w_abs_a),
        .i_op_b (w_abs_b),
        .o_hi   (w_dp_hi),
        .o_lo   (w_dp_lo)
    );

    // ------------------------------------------------------------------------
    // PREP successor: straight to FIX when the answer needs no iterations
    // ------------------------------------------------------------------------
`ifdef MDU_EARLY_OUT_EN
    logic w_mul_zero;
    logic w_early;
    assign w_mul_zero  = !w_is_div && ((r_a == '0) || (r_b == '0));
    assign w_early     = w_is_div ? (w_div0 || w_ovf) : w_mul_zero;
    assign w_prep_next = w_early ? S_FIX : S_CALC;
`else
    assign w_prep_next = S_CALC;
`endif

    // ------------------------------------------------------------------------
    // FIX: sign correction, special cases and result selection
    // ------------------------------------------------------------------------
    always_comb begin
        w_prod     = {w_dp_hi, w_dp_lo};
        w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;
        w_quo_fix  = r_neg ? (~w_dp_lo + 1'b1) : w_dp_lo;
        w_rem_fix  = r_neg ? (~w_dp_hi + 1'b1) : w_dp_hi;

        w_fix_result = '0;
        unique case (r_f3)
            MDU_MUL:                        w_fix_result = w_prod_fix[WIDTH-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_result = w_prod_fix[2*WIDTH-1:WIDTH];
            MDU_DIV, MDU_DIVU: begin
                if (w_div0)     w_fix_result = '1;
                else if (w_ovf) w_fix_result = c_int_min;
                else            w_fix_result = w_quo_fix;
            end
            MDU_REM, MDU_REMU: begin
                if (w_div0)     w_fix_result = r_a;
                else if (w_ovf) w_fix_result = '0;
                else            w_fix_result = w_rem_fix;
            end
            default:            w_fix_result = '0;
        endcase
`ifdef MDU_EARLY_OUT_EN
        // The datapath was never stepped for a zero multiply operand.
        if (w_mul_zero) w_fix_result = '0;
`endif
    end

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_f3     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            // Abort wins over everything, including a same-cycle start.
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_f3    <= funct3;
                        r_a     <= rs1_data;
                        r_b     <= rs2_data;
                        r_rd    <= rd_in;
                        r_busy  <= 1'b1;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_neg   <= w_neg;
                    r_count <= '0;
                    r_state <= w_prep_next;
                end
                S_CALC: begin
                    if (r_count == c_last_cnt) begin
                        r_count <= '0;
                        r_state <= S_FIX;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_result;
                    r_done   <= 1'b1;
                    r_we     <= (r_rd != 5'd0);
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign result       = r_result;
    assign rd_out       = r_rd;
    assign write_enable = r_we;

endmodule : mul_div_unit
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Scoreboard bench for mul_div_unit. Issued ops push the
//                expected result (64-bit arithmetic reference) into a queue;
//                a monitor pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        write_enable;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .funct3       (funct3),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rd_in        (rd_in),
        .flush        (flush),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .rd_out       (rd_out),
        .write_enable (write_enable)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 0;
        p  = '0;
        case (f)
            3'b000: begin p = 64'(sa * sb); return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                r = sa / sb; p = 64'(r); return p[31:0];
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 32'd0) return a;
                r = sa % sb; p = 64'(r); return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'(-$urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Drive one request. Called at a negedge; returns at the negedge right
    // after the accepting edge. b2b raises start during the done cycle, so
    // the request is only taken one edge later.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push, input bit b2b);
        int   n;
        exp_t e;
        n = 0;
        if (b2b) begin
            while (!done && n < 200) begin @(negedge clk); n++; end
        end else begin
            while ((busy || done) && n < 200) begin @(negedge clk); n++; end
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL issue_wait_timeout busy=%0b done=%0b", busy, done);
        end
        start    = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        @(negedge clk);
        if (b2b) @(negedge clk);
        start = 1'b0;
        if (push) begin
            e.res = ref_model(f, a, b);
            e.rd  = rd;
            e.acc = cyc;
            q.push_back(e);
            last_res = e.res;
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && done) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=%h expected=none", result);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("rd_out", 32'(rd_out), 32'(e.rd));
                    chk("write_enable", 32'(write_enable), 32'(e.rd != 5'd0));
                    chk("latency", 32'(cyc - e.acc), 32'(MDU_LATENCY));
                end
            end
        end
    end

    initial begin : stim
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd_out", 32'(rd_out), 32'd0);
        chk("rst_we", 32'(write_enable), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(MDU_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 1'b0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        issue(MDU_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 1'b1, 1'b0);
        issue(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0);
        issue(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 1'b0);
        issue(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, 1'b0);
        issue(MDU_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, 1'b0);
        issue(MDU_DIVU, 32'd100, 32'd7, 5'd7, 1'b1, 1'b0);
        issue(MDU_REMU, 32'd100, 32'd7, 5'd8, 1'b1, 1'b0);
        issue(MDU_DIV,  32'd5, 32'd0, 5'd9, 1'b1, 1'b0);
        issue(MDU_REM,  32'd5, 32'd0, 5'd10, 1'b1, 1'b0);
        issue(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 1'b0);
        issue(MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, 1'b0);
        issue(MDU_MUL,  32'd3, 32'd4, 5'd0, 1'b1, 1'b0);
        // Back-to-back: start held in the done cycle is taken one edge later
        issue(MDU_DIVU, 32'hDEAD_BEEF, 32'd13, 5'd14, 1'b1, 1'b1);

        // start while busy is ignored; only the first op completes
        issue(MDU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        start = 1'b1; funct3 = MDU_DIV; rs1_data = 32'd99; rs2_data = 32'd3; rd_in = 5'd16;
        @(negedge clk);
        start = 1'b0;

        // flush in the middle of CALC: no done, result held
        issue(MDU_MUL, 32'd11, 32'd13, 5'd17, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_result_held", result, last_res);
        repeat (40) @(negedge clk);
        chk("flush_no_done_result", result, last_res);

        // flush beats start in the same cycle
        start = 1'b1; flush = 1'b1; funct3 = MDU_MUL; rs1_data = 32'd2; rs2_data = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_over_start_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-CALC
        issue(MDU_DIV, 32'd1000, 32'd7, 5'd18, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_rd_out", 32'(rd_out), 32'd0);
        chk("arst_we", 32'(write_enable), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        last_res = '0;
        @(negedge clk);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            rd = 5'($urandom_range(0, 31));
            issue(f, a, b, rd, 1'b1, (i % 5) == 4);
        end

        // Drain
        n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d expected=0 outstanding", q.size());
        end
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mul_div_unit
`default_nettype wire
